// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: 1-to-2 demultiplexer with an independent 2-entry FIFO on each output port
module demux_1to2_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  sel1,
    input  logic                  sel2,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic                  err,
    output logic [ERR_W-1:0]      err_count
);
    // index 0 is port A, index 1 is port B
    logic [DATA_WIDTH-1:0] r_mem [2][2];
    logic [1:0]            r_count [2];
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic                  r_err;
    logic [ERR_W-1:0]      r_err_count;
    logic [1:0]            w_route;
    logic [1:0]            w_full;
    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic                  w_accept;
    logic                  w_drop;

    assign a_valid   = r_count[0] != 2'd0;
    assign b_valid   = r_count[1] != 2'd0;
    assign a_data    = r_mem[0][r_rptr[0]];
    assign b_data    = r_mem[1][r_rptr[1]];
    assign err       = r_err;
    assign err_count = r_err_count;

    // one-hot route with sel1 priority; readiness looks only at registered counts
    always_comb begin
        w_route  = {~sel1 & sel2, sel1};
        w_full   = {r_count[1] == 2'd2, r_count[0] == 2'd2};
        in_ready = ~|(w_route & w_full);
        w_accept = in_valid & in_ready;
        w_push   = w_accept ? w_route : 2'b00;
        w_drop   = w_accept & ~|w_route;
        w_pop    = {b_valid & b_ready, a_valid & a_ready};
    end

    // pointers, occupancy and the saturating error counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count[0]  <= 2'd0;
            r_count[1]  <= 2'd0;
            r_wptr      <= 2'b00;
            r_rptr      <= 2'b00;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) r_wptr[p] <= ~r_wptr[p];
                if (w_pop[p]) r_rptr[p] <= ~r_rptr[p];
                r_count[p] <= r_count[p] + 2'(w_push[p]) - 2'(w_pop[p]);
            end
            r_err <= w_drop;
            if (w_drop && r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    // FIFO storage is left unreset; stale entries are hidden by the counts
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) r_mem[p][r_wptr[p]] <= in_data;
        end
    end
endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: directed scenarios plus randomized traffic checked against a queue model
module tb_demux_1to2_buf;
    localparam int DW = 32;
    localparam int EW = 8;
    localparam int SAT = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          sel1 = 1'b0;
    logic          sel2 = 1'b0;
    logic          a_ready = 1'b1;
    logic          b_ready = 1'b1;
    logic          in_ready;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          err;
    logic [EW-1:0] err_count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            m_err = 1'b0;
    int            m_cnt = 0;
    bit            m_acc, m_pa, m_pb;

    always #5 clk = ~clk;

    demux_1to2_buf #(.DATA_WIDTH(DW), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .sel1(sel1), .sel2(sel2), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .err(err), .err_count(err_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return sel1 ? (qa.size() != 2) : sel2 ? (qb.size() != 2) : 1'b1;
    endfunction

    // compare against the model, then advance the model with the inputs the next edge will sample
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ready()));
            chk("a_valid", 64'(a_valid), 64'(qa.size() > 0));
            chk("b_valid", 64'(b_valid), 64'(qb.size() > 0));
            if (qa.size() > 0) chk("a_data", 64'(a_data), 64'(qa[0]));
            if (qb.size() > 0) chk("b_data", 64'(b_data), 64'(qb[0]));
            chk("err", 64'(err), 64'(m_err));
            chk("err_count", 64'(err_count), 64'(m_cnt));
        end
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            m_acc = in_valid && exp_ready();
            m_pa  = qa.size() > 0 && a_ready;
            m_pb  = qb.size() > 0 && b_ready;
            if (m_pa) void'(qa.pop_front());
            if (m_pb) void'(qb.pop_front());
            m_err = 1'b0;
            if (m_acc) begin
                if (sel1) qa.push_back(in_data);
                else if (sel2) qb.push_back(in_data);
                else begin
                    m_err = 1'b1;
                    if (m_cnt < SAT) m_cnt++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] d, input logic s1, input logic s2);
        in_valid = 1'b1;
        in_data  = d;
        sel1     = s1;
        sel2     = s2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst a_valid", 64'(a_valid), 64'd0);
        chk("rst b_valid", 64'(b_valid), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        // V1
        put(32'h11, 1, 0); cyc();
        chk("v1 a_valid", 64'(a_valid), 64'd1);
        chk("v1 a_data", 64'(a_data), 64'h11);
        put(32'h22, 0, 1); cyc();
        chk("v1 a_valid drained", 64'(a_valid), 64'd0);
        chk("v1 b_valid", 64'(b_valid), 64'd1);
        chk("v1 b_data", 64'(b_data), 64'h22);
        chk("v1 err", 64'(err), 64'd0);
        idle(); cyc();
        chk("v1 b_valid drained", 64'(b_valid), 64'd0);
        // V2
        a_ready = 1'b0;
        put(32'hA0, 1, 0); cyc();
        put(32'hA1, 1, 0); cyc();
        put(32'hA2, 1, 0); #1;
        chk("v2 in_ready full", 64'(in_ready), 64'd0);
        cyc();
        chk("v2 a_data stable", 64'(a_data), 64'hA0);
        a_ready = 1'b1; #1;
        chk("v2 no bypass", 64'(in_ready), 64'd0);
        cyc();
        chk("v2 in_ready rises", 64'(in_ready), 64'd1);
        chk("v2 a_data A1", 64'(a_data), 64'hA1);
        cyc();
        chk("v2 a_data A2", 64'(a_data), 64'hA2);
        idle(); cyc();
        chk("v2 a_valid drained", 64'(a_valid), 64'd0);
        // V3
        a_ready = 1'b0;
        put(32'hC0, 1, 0); cyc();
        put(32'hC1, 1, 0); cyc();
        put(32'hB5, 0, 1); #1;
        chk("v3 in_ready B", 64'(in_ready), 64'd1);
        cyc();
        chk("v3 b_valid", 64'(b_valid), 64'd1);
        chk("v3 b_data", 64'(b_data), 64'hB5);
        chk("v3 a_data held", 64'(a_data), 64'hC0);
        idle(); a_ready = 1'b1;
        repeat (3) cyc();
        chk("v3 a drained", 64'(a_valid), 64'd0);
        // V4
        put(32'h33, 1, 1); cyc();
        chk("v4 a_data", 64'(a_data), 64'h33);
        chk("v4 b_valid", 64'(b_valid), 64'd0);
        idle(); cyc();
        // V5
        for (int i = 0; i < 300; i++) begin
            put($urandom, 0, 0); cyc();
            chk("v5 err pulse", 64'(err), 64'd1);
        end
        chk("v5 err_count sat", 64'(err_count), 64'd255);
        idle(); cyc();
        chk("v5 err ends", 64'(err), 64'd0);
        chk("v5 err_count held", 64'(err_count), 64'd255);
        // V6
        a_ready = 1'b0;
        put(32'hD0, 1, 0); cyc();
        put(32'hD1, 1, 0); cyc();
        chk("v6 a_valid before", 64'(a_valid), 64'd1);
        rst_n = 1'b0;
        put(32'hEE, 0, 0); cyc();
        rst_n = 1'b1;
        idle(); #1;
        chk("v6 a_valid reset", 64'(a_valid), 64'd0);
        chk("v6 err_count reset", 64'(err_count), 64'd0);
        chk("v6 err reset", 64'(err), 64'd0);
        put(32'h44, 1, 0); a_ready = 1'b1; cyc();
        chk("v6 first word", 64'(a_data), 64'h44);
        idle(); cyc();
        // randomized traffic with varying back-pressure and rare resets
        for (int i = 0; i < 4000; i++) begin
            int mode;
            mode     = (i / 64) % 4;
            rst_n    = $urandom_range(0, 299) != 0;
            in_valid = $urandom_range(0, 3) != 0;
            sel1     = $urandom_range(0, 2) == 0;
            sel2     = $urandom_range(0, 1) == 0;
            in_data  = $urandom;
            a_ready  = mode == 1 ? 1'b0 : $urandom_range(0, 3) != 0;
            b_ready  = mode == 2 ? 1'b0 : $urandom_range(0, 1) != 0;
            cyc();
        end
        rst_n = 1'b1;
        idle(); a_ready = 1'b1; b_ready = 1'b1;
        repeat (4) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
